// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write-back arbiter.
// Optional feature macro: REGBANK_WB_RR_EN (round-robin grant selection).
package regbank_pkg;

  localparam int DEF_BUS  = 32;
  localparam int DEF_DIR  = 4;
  localparam int DEF_NREQ = 3;
  localparam int REG_PC   = 15;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MEM = 2'd1,
    REQ_KRN = 2'd2
  } req_idx_e;

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selector: searches valids starting one past the pointer.
// A fixed pointer of N-1 degenerates to lowest-index-wins.
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter int N  = DEF_NREQ,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  // first valid requester after ptr, wrapping modulo N
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter with registered bank port and busy scoreboard.
// Optional feature macro: REGBANK_WB_RR_EN (round-robin grant selection).
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int BUS  = DEF_BUS,
  parameter int DIR  = DEF_DIR,
  parameter int NREQ = DEF_NREQ
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][DIR-1:0]  req_rd,
  input  logic [NREQ-1:0][BUS-1:0]  req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      rsv_valid,
  input  logic [DIR-1:0]            rsv_rd,
  input  logic [DIR-1:0]            rs,
  input  logic [DIR-1:0]            rx,
  input  logic [DIR-1:0]            rk,
  output logic                      hazard,
  output logic                      bank_we,
  output logic [DIR-1:0]            bank_rd,
  output logic [BUS-1:0]            bank_wb,
  output logic                      err_pc_write
);

  localparam int PW = ptr_w(NREQ);
  localparam int NR = 1 << DIR;
  localparam logic [DIR-1:0] PC = DIR'(REG_PC);

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   ptr;
  logic            xfer;
  logic [DIR-1:0]  sel_rd;
  logic [BUS-1:0]  sel_wb;
  logic            sel_pc;
  logic [NR-1:0]   busy;
  logic [NR-1:0]   set_m;
  logic [NR-1:0]   clr_m;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

`ifdef REGBANK_WB_RR_EN
  logic [PW-1:0] gnt_idx;

  // encode the one-hot grant for the pointer
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = PW'(i);
    end
  end

  // pointer tracks the last granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= PW'(NREQ - 1);
    else if (xfer) ptr <= gnt_idx;
  end
`else
  assign ptr = PW'(NREQ - 1);
`endif

  // mux the granted requester's destination and data
  always_comb begin
    sel_rd = '0;
    sel_wb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd = req_rd[i];
        sel_wb = req_data[i];
      end
    end
  end

  assign sel_pc = (sel_rd == PC);

  // registered bank write port; PC writes only raise the error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_we      <= 1'b0;
      bank_rd      <= '0;
      bank_wb      <= '0;
      err_pc_write <= 1'b0;
    end else begin
      bank_we      <= xfer && !sel_pc;
      err_pc_write <= xfer && sel_pc;
      if (xfer && !sel_pc) begin
        bank_rd <= sel_rd;
        bank_wb <= sel_wb;
      end
    end
  end

  // scoreboard set/clear masks; PC is never reserved
  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (rsv_valid && (rsv_rd != PC)) set_m[rsv_rd] = 1'b1;
    if (xfer) clr_m[sel_rd] = 1'b1;
  end

  // busy bits: set wins over a same-edge clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~clr_m) | set_m;
  end

  assign hazard = busy[rs] | busy[rx] | busy[rk];

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench: directed scenarios then random traffic
// against a behavioural model of arbitration and scoreboard.
module tb_regbank_wb_arbiter;

  localparam int BUS  = 32;
  localparam int DIR  = 4;
  localparam int NREQ = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][DIR-1:0]  req_rd;
  logic [NREQ-1:0][BUS-1:0]  req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      rsv_valid;
  logic [DIR-1:0]            rsv_rd;
  logic [DIR-1:0]            rs, rx, rk;
  logic                      hazard;
  logic                      bank_we;
  logic [DIR-1:0]            bank_rd;
  logic [BUS-1:0]            bank_wb;
  logic                      err_pc_write;

  regbank_wb_arbiter #(
    .BUS  (BUS),
    .DIR  (DIR),
    .NREQ (NREQ)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsv_valid    (rsv_valid),
    .rsv_rd       (rsv_rd),
    .rs           (rs),
    .rx           (rx),
    .rk           (rk),
    .hazard       (hazard),
    .bank_we      (bank_we),
    .bank_rd      (bank_rd),
    .bank_wb      (bank_wb),
    .err_pc_write (err_pc_write)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          mbusy [16];
  logic        m_we, m_err;
  logic [3:0]  m_rd;
  logic [31:0] m_wb;
  int          mptr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    m_we  = 1'b0;
    m_err = 1'b0;
    m_rd  = '0;
    m_wb  = '0;
    mptr  = NREQ - 1;
  endtask

  function automatic int m_pick(logic [NREQ-1:0] v);
    int start;
`ifdef REGBANK_WB_RR_EN
    start = (mptr + 1) % NREQ;
`else
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic m_hazard();
    return mbusy[rs] | mbusy[rx] | mbusy[rk];
  endfunction

  // one clock: check comb outputs mid-cycle, registered after edge
  task automatic cycle(string tag);
    int g;
    logic [NREQ-1:0] er;
    @(negedge clk);
    g  = m_pick(req_valid);
    er = (g < 0) ? '0 : NREQ'(1 << g);
    chk({tag, " ready"}, 64'(req_ready), 64'(er));
    chk({tag, " hazard"}, 64'(hazard), 64'(m_hazard()));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      mptr = g;
      mbusy[req_rd[g]] = 1'b0;
      if (req_rd[g] == 4'd15) begin
        m_we  = 1'b0;
        m_err = 1'b1;
      end else begin
        m_we  = 1'b1;
        m_err = 1'b0;
        m_rd  = req_rd[g];
        m_wb  = req_data[g];
      end
    end else begin
      m_we  = 1'b0;
      m_err = 1'b0;
    end
    if (rsv_valid && rsv_rd != 4'd15) mbusy[rsv_rd] = 1'b1;
    chk({tag, " bank_we"}, 64'(bank_we), 64'(m_we));
    chk({tag, " err_pc"}, 64'(err_pc_write), 64'(m_err));
    chk({tag, " bank_rd"}, 64'(bank_rd), 64'(m_rd));
    chk({tag, " bank_wb"}, 64'(bank_wb), 64'(m_wb));
  endtask

  task automatic idle_in();
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_rd    = '0;
    rs        = '0;
    rx        = '0;
    rk        = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst bank_we", 64'(bank_we), 64'd0);
    chk("rst bank_rd", 64'(bank_rd), 64'd0);
    chk("rst bank_wb", 64'(bank_wb), 64'd0);
    chk("rst err_pc", 64'(err_pc_write), 64'd0);
    chk("rst hazard", 64'(hazard), 64'd0);
    chk("rst ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;

    // ALU alone, rd=3
    req_valid   = 3'b001;
    req_rd[0]   = 4'd3;
    req_data[0] = 32'hDEADBEEF;
    cycle("alu");
    chk("alu we", 64'(bank_we), 64'd1);
    chk("alu rd", 64'(bank_rd), 64'd3);
    chk("alu wb", 64'(bank_wb), 64'hDEADBEEF);
    idle_in();
    cycle("alu idle");
    chk("alu we drop", 64'(bank_we), 64'd0);
    chk("alu wb hold", 64'(bank_wb), 64'hDEADBEEF);

    // contention for six cycles
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i]   = DIR'(i + 1);
      req_data[i] = 32'h1000 + i;
    end
    for (int c = 0; c < 6; c++) cycle("contend");
    idle_in();

    // reservation on r5, MEM clears it
    rsv_valid = 1'b1;
    rsv_rd    = 4'd5;
    rs        = 4'd5;
    cycle("rsv5");
    chk("rsv5 hazard", 64'(hazard), 64'd1);
    rsv_valid   = 1'b0;
    req_valid   = 3'b010;
    req_rd[1]   = 4'd5;
    req_data[1] = 32'hCAFE0005;
    cycle("mem5");
    chk("mem5 hazard", 64'(hazard), 64'd0);
    idle_in();

    // same-edge set and clear on r7
    rsv_valid   = 1'b1;
    rsv_rd      = 4'd7;
    rx          = 4'd7;
    req_valid   = 3'b001;
    req_rd[0]   = 4'd7;
    req_data[0] = 32'h77;
    cycle("setwin");
    chk("setwin hazard", 64'(hazard), 64'd1);
    idle_in();
    rx = 4'd7;
    cycle("setwin hold");
    chk("setwin hazard2", 64'(hazard), 64'd1);

    // KRN write to PC plus PC reservation
    idle_in();
    req_valid   = 3'b100;
    req_rd[2]   = 4'd15;
    req_data[2] = 32'h1234;
    rsv_valid   = 1'b1;
    rsv_rd      = 4'd15;
    rk          = 4'd15;
    cycle("pc");
    chk("pc we", 64'(bank_we), 64'd0);
    chk("pc err", 64'(err_pc_write), 64'd1);
    chk("pc hazard", 64'(hazard), 64'd0);
    idle_in();
    rk = 4'd15;
    cycle("pc after");
    chk("pc err drop", 64'(err_pc_write), 64'd0);

    // reset right after a transfer
    idle_in();
    rsv_valid   = 1'b1;
    rsv_rd      = 4'd9;
    req_valid   = 3'b010;
    req_rd[1]   = 4'd2;
    req_data[1] = 32'hABCD;
    cycle("prerst");
    rs    = 4'd9;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midrst we", 64'(bank_we), 64'd0);
    chk("midrst hazard", 64'(hazard), 64'd0);
    chk("midrst rd", 64'(bank_rd), 64'd0);
    req_valid = 3'b111;
    rsv_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("postrst");
    chk("postrst rd", 64'(bank_rd), 64'(req_rd[0]));

    // random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        req_rd[i]   = DIR'($urandom_range(0, 15));
        req_data[i] = $urandom;
      end
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_rd    = DIR'($urandom_range(0, 15));
      rs        = DIR'($urandom_range(0, 15));
      rx        = DIR'($urandom_range(0, 15));
      rk        = DIR'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
